adder_result_stage: RTL and testbench
=====================================

Name: adder_result_stage

Overview:
Registered output stage directly downstream of the 32-bit carry look-ahead adder. It captures the adder's combinational Sum/Cout together with the operand sign bits, derives the status flags (zero, negative, carry, signed overflow), and presents them on a valid/ready interface. A two-entry skid buffer keeps full throughput (one result per clock) under downstream backpressure. A wrapping 16-bit counter tracks delivered results.

Parameters:
WIDTH, 32, datapath width; must match the adder width.
CNT_W, 16, width of the delivered-result counter.

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  upstream (adder side) result present this cycle
in_ready  output  1  stage can accept a result this cycle
in_sum  input  WIDTH  adder Sum
in_cout  input  1  adder Cout
in_a_msb  input  1  A[WIDTH-1] of the operands that produced in_sum
in_b_msb  input  1  B[WIDTH-1] of the operands that produced in_sum
out_valid  output  1  registered result present
out_ready  input  1  downstream accepts result
out_sum  output  WIDTH  registered sum
out_cout  output  1  registered carry-out (unsigned carry flag)
out_zero  output  1  1 when out_sum == 0; Cout does not affect it
out_neg  output  1  out_sum[WIDTH-1]
out_ovf  output  1  signed overflow
out_count  output  CNT_W  number of completed output handshakes, modulo 2^CNT_W

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, in_ready=1, out_sum=0, out_cout=0, out_zero=0, out_neg=0, out_ovf=0, out_count=0. Skid entry invalid. Any in-flight result is dropped, with no partial output.
- Input handshake: accept when in_valid && in_ready. Output handshake: complete when out_valid && out_ready.
- Flag computation happens at capture, from input-side signals:
  - zero = (in_sum == 0)
  - neg = in_sum[WIDTH-1]
  - ovf = (in_a_msb == in_b_msb) && (in_sum[WIDTH-1] != in_a_msb)
  - cout = in_cout
- Storage: main register drives out_*; skid register holds one extra entry (sum, cout, flags). Each entry is WIDTH+4 bits.
- in_ready is a registered signal, equal to !skid_valid. It is not combinationally dependent on out_ready.
- Per-cycle update, evaluated with pre-edge state:
  - Main empty or main draining (out_ready=1), skid empty, input accepted: load main from input. out_valid=1.
  - Main holding (out_valid=1, out_ready=0), input accepted: load skid. in_ready goes 0 next cycle.
  - Main draining, skid valid: main <= skid, skid invalid, in_ready goes 1 next cycle. No input can be accepted this cycle because in_ready=0.
  - Main draining, skid empty, no input: out_valid goes 0.
- Latency: accepted input appears on out_* the next cycle (1-cycle latency) when unobstructed. Sustained in_valid=out_ready=1 gives 1 result/cycle.
- Ordering: strict FIFO. Results are never reordered, duplicated or lost while rst_n is high.
- out_* stays stable while out_valid=1 and out_ready=0.
- out_count increments by 1 on each output handshake. It wraps from 2^CNT_W-1 to 0 with no sticky flag.
- When out_valid=0, out_* data holds its last value. Consumers ignore it.

Test Plan:
- Reset: assert rst_n=0 mid-stream with the skid full -> next cycle out_valid=0, in_ready=1, out_count=0. After release, the first new input appears alone with 1-cycle latency.
- Signed overflow: in_sum=0x80000000, cout=0, a_msb=0, b_msb=0 (0x7FFFFFFF+1) -> out_sum=0x80000000, neg=1, ovf=1, zero=0, cout=0.
- Carry/zero: in_sum=0x00000000, cout=1, a_msb=1, b_msb=0 (0xFFFFFFFF+1) -> zero=1, cout=1, ovf=0, neg=0.
- Backpressure: out_ready=0, push results R1 then R2 on consecutive cycles -> in_ready=0 after R2 is accepted, and out_sum holds R1. Raise out_ready -> R1 then R2 on consecutive cycles, and in_ready returns to 1 the cycle after R1 drains.
- Streaming: 100 back-to-back results with in_valid=out_ready=1 -> 100 outputs in order, no bubbles after the first, out_count=100.
- Counter wrap: with CNT_W=4, complete 17 output handshakes -> out_count=1.

Source files
------------

// File: rtl/adder_result_stage_if.sv
// Handshake bundle between the CLA adder, the result stage and its consumer.
// The master modport is the adder/consumer side; the slave modport is the stage itself.
interface adder_result_stage_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_sum;
    logic             in_cout;
    logic             in_a_msb;
    logic             in_b_msb;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_zero;
    logic             out_neg;
    logic             out_ovf;
    logic [CNT_W-1:0] out_count;

    modport master (
        output in_valid, in_sum, in_cout, in_a_msb, in_b_msb, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_zero, out_neg, out_ovf, out_count
    );

    modport slave (
        input  in_valid, in_sum, in_cout, in_a_msb, in_b_msb, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_zero, out_neg, out_ovf, out_count
    );
endinterface

// File: rtl/adder_result_stage.sv
// Registered result stage after the CLA adder: captures sum/cout, derives status
// flags, and delivers them over valid/ready with a one-entry skid for full throughput.
module adder_result_stage #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    adder_result_stage_if.slave  bus
);
    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             zero;
        logic             neg;
        logic             ovf;
    } entry_t;

    entry_t           r_main;
    entry_t           r_skid;
    entry_t           w_in;
    logic             r_out_valid;
    logic             r_skid_valid;
    logic [CNT_W-1:0] r_count;
    logic             w_accept;
    logic             w_drain;

    // Flags are derived from the adder-side signals so the output path is register-only.
    always_comb begin
        w_in.sum  = bus.in_sum;
        w_in.cout = bus.in_cout;
        w_in.zero = (bus.in_sum == '0);
        w_in.neg  = bus.in_sum[WIDTH-1];
        w_in.ovf  = (bus.in_a_msb == bus.in_b_msb) && (bus.in_sum[WIDTH-1] != bus.in_a_msb);
    end

    assign w_accept = bus.in_valid && !r_skid_valid;
    assign w_drain  = r_out_valid && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main       <= '0;
            r_skid       <= '0;
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (r_skid_valid) begin
            // in_ready is low here, so the only possible move is skid -> main.
            if (w_drain) begin
                r_main       <= r_skid;
                r_skid_valid <= 1'b0;
            end
        end else if (w_accept) begin
            if (!r_out_valid || bus.out_ready) begin
                r_main      <= w_in;
                r_out_valid <= 1'b1;
            end else begin
                r_skid       <= w_in;
                r_skid_valid <= 1'b1;
            end
        end else if (w_drain) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_drain) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign bus.in_ready  = !r_skid_valid;
    assign bus.out_valid = r_out_valid;
    assign bus.out_sum   = r_main.sum;
    assign bus.out_cout  = r_main.cout;
    assign bus.out_zero  = r_main.zero;
    assign bus.out_neg   = r_main.neg;
    assign bus.out_ovf   = r_main.ovf;
    assign bus.out_count = r_count;
endmodule

// File: tb/tb_adder_result_stage.sv
// Scoreboard bench for adder_result_stage: operands go through a plain-arithmetic
// adder model, expected results are queued on accept and popped on each output handshake.
module tb_adder_result_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    adder_result_stage_if #(.WIDTH(32), .CNT_W(16)) bus ();
    adder_result_stage_if #(.WIDTH(32), .CNT_W(4))  bus4 ();

    adder_result_stage #(.WIDTH(32), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    adder_result_stage #(.WIDTH(32), .CNT_W(4))  dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    // Narrow-counter copy sees exactly the same traffic.
    assign bus4.in_valid  = bus.in_valid;
    assign bus4.in_sum    = bus.in_sum;
    assign bus4.in_cout   = bus.in_cout;
    assign bus4.in_a_msb  = bus.in_a_msb;
    assign bus4.in_b_msb  = bus.in_b_msb;
    assign bus4.out_ready = bus.out_ready;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        zero;
        logic        neg;
        logic        ovf;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned hs = 0;
    bit          mon_en = 0;
    int          occ;
    exp_t        e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t   r;
        longint sa;
        logic [32:0] u;
        u  = {1'b0, a} + {1'b0, b};
        sa = longint'($signed(a)) + longint'($signed(b));
        r.sum  = u[31:0];
        r.cout = u[32];
        r.zero = (u[31:0] == 32'd0);
        r.neg  = u[31];
        r.ovf  = (sa > 64'sd2147483647) || (sa < -64'sd2147483648);
        return r;
    endfunction

    // One clock of stimulus: inputs change on the falling edge, accept is judged pre-posedge.
    task automatic drive(input bit v, input bit r, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] u;
        @(negedge clk);
        u = {1'b0, a} + {1'b0, b};
        bus.in_valid  = v;
        bus.out_ready = r;
        bus.in_sum    = u[31:0];
        bus.in_cout   = u[32];
        bus.in_a_msb  = a[31];
        bus.in_b_msb  = b[31];
        #2;
        if (rst_n && v && bus.in_ready) q.push_back(model(a, b));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        q.delete();
        hs = 0;
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_count", bus.out_count, 0);
        chk("rst_sum", bus.out_sum, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: occupancy-based status checks, then pop-and-compare on handshake.
    always @(negedge clk) begin
        #1;
        if (rst_n && mon_en) begin
            occ = q.size();
            chk("out_valid", bus.out_valid, occ > 0);
            chk("in_ready", bus.in_ready, occ < 2);
            chk("out_count", bus.out_count, hs % 65536);
            chk("out_count4", bus4.out_count, hs % 16);
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("sum", bus.out_sum, e.sum);
                    chk("cout", bus.out_cout, e.cout);
                    chk("zero", bus.out_zero, e.zero);
                    chk("neg", bus.out_neg, e.neg);
                    chk("ovf", bus.out_ovf, e.ovf);
                end
                hs++;
            end
        end
    end

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 7))
            0: return 32'h7FFF_FFFF;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bus.in_valid = 0; bus.out_ready = 0; bus.in_sum = '0;
        bus.in_cout = 0; bus.in_a_msb = 0; bus.in_b_msb = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("init_out_valid", bus.out_valid, 0);
        chk("init_in_ready", bus.in_ready, 1);
        chk("init_count", bus.out_count, 0);
        chk("init_flags", {bus.out_cout, bus.out_zero, bus.out_neg, bus.out_ovf}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1;

        // Signed overflow and carry/zero corners.
        drive(1, 1, 32'h7FFF_FFFF, 32'h0000_0001);
        drive(1, 1, 32'hFFFF_FFFF, 32'h0000_0001);
        #1;
        chk("ovf_vec", {bus.out_sum, bus.out_cout, bus.out_zero, bus.out_neg, bus.out_ovf},
            {32'h8000_0000, 4'b0011});
        drive(0, 1, 0, 0);
        #1;
        chk("carry_zero_vec", {bus.out_sum, bus.out_cout, bus.out_zero, bus.out_neg, bus.out_ovf},
            {32'h0000_0000, 4'b1100});
        drive(0, 1, 0, 0);

        // Backpressure: R1 holds, R2 goes to skid, then both drain in order.
        drive(1, 0, 32'h0000_1111, 32'h0000_0000);
        drive(1, 0, 32'h0000_2222, 32'h0000_0000);
        drive(0, 0, 0, 0);
        chk("bp_in_ready", bus.in_ready, 0);
        chk("bp_hold", bus.out_sum, 32'h1111);
        drive(0, 1, 0, 0);
        chk("bp_r1_first", bus.out_sum, 32'h1111);
        drive(0, 1, 0, 0);
        chk("bp_r2_second", bus.out_sum, 32'h2222);
        chk("bp_ready_back", bus.in_ready, 1);
        drive(0, 1, 0, 0);

        // Reset mid-stream with the skid full, then a lone result after release.
        drive(1, 0, 32'h0000_00AA, 32'h0);
        drive(1, 0, 32'h0000_00BB, 32'h0);
        drive(0, 0, 0, 0);
        chk("pre_rst_skid_full", bus.in_ready, 0);
        do_reset();
        drive(1, 1, 32'h0000_0123, 32'h0);
        drive(0, 1, 0, 0);
        chk("post_rst_valid", bus.out_valid, 1);
        chk("post_rst_sum", bus.out_sum, 32'h123);
        drive(0, 1, 0, 0);
        chk("post_rst_alone", bus.out_valid, 0);

        // Streaming: 100 back-to-back results.
        do_reset();
        for (int i = 0; i < 100; i++) drive(1, 1, $urandom, $urandom);
        drive(0, 1, 0, 0);
        drive(0, 1, 0, 0);
        chk("stream_count", bus.out_count, 100);
        chk("stream_count4", bus4.out_count, 100 % 16);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) < 3, rnd_op(), rnd_op());
        end
        for (int i = 0; i < 4; i++) drive(0, 1, 0, 0);
        chk("final_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
